avalon_ram_model: RTL and testbench
===================================

# avalon_ram_model

Parametrised Avalon-MM slave memory that is the next-generation program/data RAM for the MIPS CPU testbenches, connecting directly to the CPU bus (address, read, write, waitrequest, writedata, byteenable, readdata). It adds configurable depth, a base address, fixed or pseudo-random wait states, a clocked backdoor load port, and sticky protocol-error reporting. The CPU top level and per-instruction benches instantiate it in place of the fixed-latency RAM.

## Interface
- ADDR_BITS, 10: word-address width; depth = 2**ADDR_BITS 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; must be word-aligned.
- WAIT_CYCLES, 0: maximum number of waitrequest stall cycles per transfer.
- WAIT_MODE, 0: 0 = every transfer stalls exactly WAIT_CYCLES; 1 = pseudo-random stall of 0..WAIT_CYCLES.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- address  in  32  byte address from CPU.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  bit i enables writedata[8i+7:8i].
- waitrequest  out  1  slave stall.
- readdata  out  32  read data, valid when read && !waitrequest.
- load_en  in  1  backdoor word write.
- load_addr  in  ADDR_BITS  backdoor word index.
- load_data  in  32  backdoor data.
- mem_clear  in  1  synchronous zeroing of every word.
- err  out  1  sticky protocol/range error.

## Operation
- Word index = (address - BASE_ADDR) >> 2. In range when 0 <= offset < 4*2**ADDR_BITS.
- FSM states IDLE, WAIT.
  - IDLE, request seen (read xor write), target = 0: waitrequest 0, transfer completes this cycle, stay IDLE.
  - IDLE, request seen, target > 0: waitrequest 1, latch address/direction, cnt <= 1, go WAIT.
  - WAIT: waitrequest = (cnt < target), cnt increments while stalling; when waitrequest is 0 the transfer completes at that edge, then IDLE.
  - WAIT, request dropped: abandon, no write, IDLE, set err.
  - WAIT, address or direction differs from latched value: set err, continue with the latched transfer.
- Target: mode 0 = WAIT_CYCLES; mode 1 = lfsr % (WAIT_CYCLES+1), sampled at request start; the LFSR (16-bit, taps 16,14,13,11) advances once per started transfer.
- Write completion: each enabled byte lane is written; disabled lanes are unchanged.
- readdata = mem[index] when read && !waitrequest && in range, else 32'h0 (combinational array read).
- read and write both asserted: no access, waitrequest 0, set err.
- Misaligned address (address[1:0] != 0) or out of range: no access, readdata 0, transfer still completes after its stall, set err.
- Backdoor: load_en writes load_data to mem[load_addr] at the edge. If a bus write to the same word completes at the same edge, the backdoor wins for all bytes.
- mem_clear has priority over both writers and zeroes all words at the edge.
- Reset clears the FSM to IDLE, cnt to 0, lfsr to SEED and err to 0. Memory contents are preserved, so a loaded program survives a CPU reset.

## Timing
- Reset values: waitrequest 0, readdata 0, err 0.
- A transfer with target N has waitrequest high for exactly N cycles from request assertion and completes on cycle N+1.
- Back-to-back requests: a new transfer may start the cycle after completion.
- Reset asserted mid-WAIT: FSM goes to IDLE immediately and no write occurs.
- err is cleared only by reset.

## Structure
- Package avalon_ram_pkg holds the state enum (IDLE, WAIT), the LFSR tap constant, and the default SEED.
- Sub-module wait_lfsr: a 16-bit Galois LFSR with advance and async reset, outputting the current value.

## Test plan
- WAIT_CYCLES=0: backdoor-load 0x24020010 at word 1; read at 0x04 gives waitrequest 0 and readdata 0x24020010 in the same cycle.
- WAIT_CYCLES=3, mode 0: write 0xDEADBEEF with byteenable 4'b0101 over 0x0; waitrequest is high for exactly 3 cycles; a later read returns 0x00AD00EF.
- Mode 1, WAIT_CYCLES=7, SEED=16'hACE1: run 64 reads; every stall is in 0..7, the sequence matches the reference LFSR model, and at least two distinct stall lengths occur.
- Drop read during WAIT, then a same-cycle bus write and backdoor load to one word: err is 1, and the word holds the load_data value.
- Out-of-range read at BASE_ADDR + 4*2**ADDR_BITS and a misaligned read at 0x2: readdata 0 and err 1; reset clears err but the preloaded words still read back.
- Assert mem_clear for one cycle: every word reads 0x0; reset mid-WAIT returns waitrequest to 0 with the target word unchanged.

Source files
------------

// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the Avalon-MM RAM model.
package avalon_ram_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/avalon_ram_model_wait_lfsr.sv
// 16-bit Galois LFSR that supplies pseudo-random stall lengths.
module wait_lfsr
  import avalon_ram_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_advance,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/avalon_ram_model.sv
// Avalon-MM slave RAM with configurable wait states, backdoor load and
// sticky protocol-error flag.
module avalon_ram_model
  import avalon_ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned WAIT_MODE   = 0,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic [3:0]           byteenable,
  output logic                 waitrequest,
  output logic [31:0]          readdata,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  input  logic                 mem_clear,
  output logic                 err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [33:0] SPAN  = 34'(1) << (ADDR_BITS + 2);

  state_t                r_state;
  logic [31:0]           r_cnt;
  logic [31:0]           r_target;
  logic [31:0]           r_addr;
  logic                  r_write;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_req;
  logic                  w_both;
  logic [15:0]           w_lfsr;
  logic [31:0]           w_start_target;
  logic [31:0]           w_cur_addr;
  logic                  w_cur_write;
  logic [32:0]           w_off;
  logic                  w_ok;
  logic [ADDR_BITS-1:0]  w_idx;
  logic                  w_wait;
  logic                  w_done;
  logic                  w_bus_wr;
  logic [31:0]           w_merged;

  assign w_req  = read ^ write;
  assign w_both = read & write;

  wait_lfsr #(
    .SEED(SEED)
  ) u_wait_lfsr (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_advance ((r_state == IDLE) && w_req),
    .o_value   (w_lfsr)
  );

  assign w_start_target = (WAIT_MODE == 1) ? (32'(w_lfsr) % (WAIT_CYCLES + 1))
                                           : WAIT_CYCLES;

  // Once stalled, decode from the latched request rather than the live bus.
  assign w_cur_addr  = (r_state == WAIT) ? r_addr  : address;
  assign w_cur_write = (r_state == WAIT) ? r_write : write;
  assign w_off       = {1'b0, w_cur_addr} - {1'b0, BASE_ADDR};
  assign w_ok        = ({1'b0, w_off} < SPAN) && (w_off[1:0] == 2'b00);
  assign w_idx       = w_off[ADDR_BITS+1:2];

  // Stall and completion decode; nothing completes while reset is held.
  always_comb begin
    w_wait = 1'b0;
    w_done = 1'b0;
    if (reset) begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            w_wait = (w_start_target != '0);
            w_done = (w_start_target == '0);
          end
        end
        WAIT: begin
          w_wait = (r_cnt < r_target);
          w_done = !w_wait && (read || write);
        end
        default: ;
      endcase
    end
  end

  assign waitrequest = w_wait;
  assign w_bus_wr    = w_done && w_cur_write && w_ok;
  assign readdata    = (w_done && read && !w_cur_write && w_ok) ? r_mem[w_idx] : '0;
  assign err         = r_err;

  // Byte-lane merge of bus write data into the addressed word.
  always_comb begin
    w_merged = r_mem[w_idx];
    if (byteenable[0]) w_merged[7:0]   = writedata[7:0];
    if (byteenable[1]) w_merged[15:8]  = writedata[15:8];
    if (byteenable[2]) w_merged[23:16] = writedata[23:16];
    if (byteenable[3]) w_merged[31:24] = writedata[31:24];
  end

  // Transfer FSM, stall counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_both) begin
            r_err <= 1'b1;
          end else if (w_req) begin
            if (!w_ok) r_err <= 1'b1;
            if (w_start_target != '0) begin
              r_state  <= WAIT;
              r_cnt    <= 32'd1;
              r_target <= w_start_target;
              r_addr   <= address;
              r_write  <= write;
            end
          end
        end
        WAIT: begin
          if (!read && !write) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            if ((address != r_addr) || w_both || (write != r_write)) r_err <= 1'b1;
            if (r_cnt < r_target) begin
              r_cnt <= r_cnt + 32'd1;
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is not reset so a loaded program survives a CPU reset.
  // Later assignment lets the backdoor override a same-edge bus write.
  always_ff @(posedge clk) begin
    if (mem_clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[ADDR_BITS'(i)] <= '0;
    end else begin
      if (w_bus_wr) r_mem[w_idx] <= w_merged;
      if (load_en)  r_mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_avalon_ram_model.sv
module tb_avalon_ram_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: no stall, 1: fixed 3 stalls, 2: random 0..7 stalls, base 0x1000
  logic        reset       [3];
  logic [31:0] address     [3];
  logic        read        [3];
  logic        write       [3];
  logic [31:0] writedata   [3];
  logic [3:0]  byteenable  [3];
  logic        waitrequest [3];
  logic [31:0] readdata    [3];
  logic        load_en     [3];
  logic [9:0]  load_addr   [3];
  logic [31:0] load_data   [3];
  logic        mem_clear   [3];
  logic        err         [3];

  bit          wait_chk  [3];
  bit          err_chk   [3];
  logic        exp_wait  [3];
  logic [31:0] exp_rdata [3];
  bit          m_err     [3];
  logic [31:0] m_mem     [3][1024];
  logic [15:0] m_lfsr = 16'hACE1;

  int n_pass = 0;
  int n_chk  = 0;

  avalon_ram_model #(.ADDR_BITS(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0),
                     .WAIT_MODE(0), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .reset(reset[0]), .address(address[0]), .read(read[0]), .write(write[0]),
    .writedata(writedata[0]), .byteenable(byteenable[0]), .waitrequest(waitrequest[0]),
    .readdata(readdata[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
    .load_data(load_data[0]), .mem_clear(mem_clear[0]), .err(err[0]));

  avalon_ram_model #(.ADDR_BITS(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3),
                     .WAIT_MODE(0), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .address(address[1]), .read(read[1]), .write(write[1]),
    .writedata(writedata[1]), .byteenable(byteenable[1]), .waitrequest(waitrequest[1]),
    .readdata(readdata[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
    .load_data(load_data[1]), .mem_clear(mem_clear[1]), .err(err[1]));

  avalon_ram_model #(.ADDR_BITS(10), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(7),
                     .WAIT_MODE(1), .SEED(16'hACE1)) u_dut2 (
    .clk(clk), .reset(reset[2]), .address(address[2]), .read(read[2]), .write(write[2]),
    .writedata(writedata[2]), .byteenable(byteenable[2]), .waitrequest(waitrequest[2]),
    .readdata(readdata[2]), .load_en(load_en[2]), .load_addr(load_addr[2]),
    .load_data(load_data[2]), .mem_clear(mem_clear[2]), .err(err[2]));

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    else n_pass++;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  // Per-cycle comparison of every DUT against the model expectations.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (wait_chk[d]) check($sformatf("waitrequest[%0d]", d), 32'(waitrequest[d]), 32'(exp_wait[d]));
      check($sformatf("readdata[%0d]", d), readdata[d], exp_rdata[d]);
      if (err_chk[d]) check($sformatf("err[%0d]", d), 32'(err[d]), 32'(m_err[d]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    read[d] = 1'b0; write[d] = 1'b0; load_en[d] = 1'b0; mem_clear[d] = 1'b0;
    exp_wait[d] = 1'b0; exp_rdata[d] = '0; wait_chk[d] = 1'b1;
  endtask

  task automatic bd_load(input int d, input int unsigned idx, input logic [31:0] v);
    load_en[d] = 1'b1; load_addr[d] = idx[9:0]; load_data[d] = v;
    tick();
    load_en[d] = 1'b0;
    m_mem[d][idx] = v;
  endtask

  task automatic next_stall(input int d, output int unsigned n);
    if (d == 0) n = 0;
    else if (d == 1) n = 3;
    else begin
      n = 32'(m_lfsr) % 8;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  endtask

  // One bus transfer with n stall cycles; optional backdoor load on the completing cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int unsigned n, input bit bd,
                      input logic [31:0] bdv, output int unsigned seen, output logic [31:0] rd);
    logic [31:0]  off;
    bit           ok;
    int unsigned  idx;
    logic [31:0]  rd_exp;
    off    = a - base_of(d);
    ok     = (a >= base_of(d)) && (off < 32'd4096) && (a[1:0] == 2'b00);
    idx    = ok ? int'(off >> 2) : 0;
    rd_exp = (!wr && ok) ? m_mem[d][idx] : '0;
    address[d] = a; read[d] = !wr; write[d] = wr; writedata[d] = wd; byteenable[d] = be;
    err_chk[d] = 1'b0;
    seen = 0;
    rd   = '0;
    for (int unsigned k = 0; k <= n; k++) begin
      exp_wait[d]  = (k < n);
      exp_rdata[d] = (k == n) ? rd_exp : '0;
      if (k == n && bd) begin
        load_en[d] = 1'b1; load_addr[d] = idx[9:0]; load_data[d] = bdv;
      end
      @(negedge clk);
      if (waitrequest[d]) seen++;
      if (k == n) rd = readdata[d];
      @(posedge clk);
      #1;
    end
    if (wr && ok) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) m_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
    end
    if (bd) m_mem[d][idx] = bdv;
    if (!ok) m_err[d] = 1'b1;
    idle(d);
    err_chk[d] = 1'b1;
  endtask

  task automatic err_at_negedge(input string nm, input int d, input logic exp);
    @(negedge clk);
    check(nm, 32'(err[d]), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n, seen, distinct;
    logic [31:0] rd;
    logic [7:0]  seen_mask;
    int unsigned pins [4];
    pins = '{1, 0, 0, 4};

    for (int d = 0; d < 3; d++) begin
      reset[d] = 1'b1; address[d] = '0; writedata[d] = '0; byteenable[d] = '0;
      load_addr[d] = '0; load_data[d] = '0; idle(d); err_chk[d] = 1'b1; m_err[d] = 1'b0;
    end
    #2;
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) reset[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) mem_clear[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      mem_clear[d] = 1'b0;
      for (int i = 0; i < 1024; i++) m_mem[d][i] = '0;
    end

    // zero-wait device
    bd_load(0, 1, 32'h2402_0010);
    xfer(0, 1'b0, 32'h4, '0, 4'h0, 0, 1'b0, '0, seen, rd);
    check("word1_read", rd, 32'h2402_0010);
    check("word1_stall", seen, 0);
    xfer(0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'b1000, 0, 1'b0, '0, seen, rd);
    xfer(0, 1'b0, 32'h10, '0, 4'h0, 0, 1'b0, '0, seen, rd);
    check("lane3_only", rd, 32'hCA00_0000);
    err_at_negedge("err_clean", 0, 1'b0);
    xfer(0, 1'b0, 32'h1000, '0, 4'h0, 0, 1'b0, '0, seen, rd);
    check("oor_read", rd, 32'h0);
    xfer(0, 1'b0, 32'h2, '0, 4'h0, 0, 1'b0, '0, seen, rd);
    check("misaligned_read", rd, 32'h0);
    err_at_negedge("err_after_bad_addr", 0, 1'b1);
    reset[0] = 1'b0; m_err[0] = 1'b0;
    tick();
    reset[0] = 1'b1;
    tick();
    err_at_negedge("err_cleared_by_reset", 0, 1'b0);
    xfer(0, 1'b0, 32'h4, '0, 4'h0, 0, 1'b0, '0, seen, rd);
    check("word1_survives_reset", rd, 32'h2402_0010);

    // read and write together: no access, no stall
    address[0] = 32'h4; read[0] = 1'b1; write[0] = 1'b1;
    writedata[0] = 32'hFFFF_FFFF; byteenable[0] = 4'hF; err_chk[0] = 1'b0;
    tick();
    idle(0); m_err[0] = 1'b1; err_chk[0] = 1'b1;
    xfer(0, 1'b0, 32'h4, '0, 4'h0, 0, 1'b0, '0, seen, rd);
    check("rw_both_no_write", rd, 32'h2402_0010);
    xfer(0, 1'b1, 32'hFFC, 32'h8765_4321, 4'hF, 0, 1'b0, '0, seen, rd);
    mem_clear[0] = 1'b1;
    tick();
    mem_clear[0] = 1'b0;
    for (int i = 0; i < 1024; i++) m_mem[0][i] = '0;
    for (int unsigned i = 0; i < 1024; i++)
      xfer(0, 1'b0, 32'(i) << 2, '0, 4'h0, 0, 1'b0, '0, seen, rd);

    // fixed three-cycle stall device
    xfer(1, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'b0101, 3, 1'b0, '0, seen, rd);
    check("write_stall_3", seen, 3);
    xfer(1, 1'b0, 32'h0, '0, 4'h0, 3, 1'b0, '0, seen, rd);
    check("partial_write_read", rd, 32'h00AD_00EF);
    check("read_stall_3", seen, 3);
    err_at_negedge("err1_clean", 1, 1'b0);

    address[1] = 32'h8; read[1] = 1'b1; err_chk[1] = 1'b0; exp_wait[1] = 1'b1;
    tick();
    read[1] = 1'b0; wait_chk[1] = 1'b0;
    tick();
    idle(1); m_err[1] = 1'b1; err_chk[1] = 1'b1;
    err_at_negedge("err_after_drop", 1, 1'b1);
    xfer(1, 1'b1, 32'hC, 32'h1111_1111, 4'hF, 3, 1'b1, 32'h5A5A_5A5A, seen, rd);
    xfer(1, 1'b0, 32'hC, '0, 4'h0, 3, 1'b0, '0, seen, rd);
    check("backdoor_wins", rd, 32'h5A5A_5A5A);

    bd_load(1, 5, 32'h1357_2468);
    address[1] = 32'h14; write[1] = 1'b1; writedata[1] = 32'hFFFF_FFFF; byteenable[1] = 4'hF;
    err_chk[1] = 1'b0; exp_wait[1] = 1'b1;
    tick();
    reset[1] = 1'b0; m_err[1] = 1'b0; exp_wait[1] = 1'b0; err_chk[1] = 1'b1;
    @(negedge clk);
    check("wait_drops_in_reset", 32'(waitrequest[1]), 32'h0);
    @(posedge clk);
    #1;
    write[1] = 1'b0;
    tick();
    reset[1] = 1'b1;
    tick();
    xfer(1, 1'b0, 32'h14, '0, 4'h0, 3, 1'b0, '0, seen, rd);
    check("reset_mid_wait_no_write", rd, 32'h1357_2468);

    // pseudo-random stall device
    for (int unsigned i = 0; i < 64; i++) bd_load(2, i, 32'hA000_0000 + 32'(i));
    seen_mask = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      next_stall(2, n);
      xfer(2, 1'b0, 32'h1000 + (32'(i) << 2), '0, 4'h0, n, 1'b0, '0, seen, rd);
      if (i < 4) check($sformatf("lfsr_stall_%0d", i), seen, pins[i]);
      if (seen < 8) seen_mask[seen[2:0]] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 8; i++) if (seen_mask[i]) distinct++;
    check("distinct_stalls_ge2", 32'(distinct >= 2), 32'h1);
    err_at_negedge("err2_clean", 2, 1'b0);
    next_stall(2, n);
    xfer(2, 1'b0, 32'h2000, '0, 4'h0, n, 1'b0, '0, seen, rd);
    check("oor_above_base", rd, 32'h0);
    next_stall(2, n);
    xfer(2, 1'b0, 32'h0FFC, '0, 4'h0, n, 1'b0, '0, seen, rd);
    check("oor_below_base", rd, 32'h0);
    err_at_negedge("err2_after_oor", 2, 1'b1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
